// File: rtl/delay_tap_ctrl_if.sv
// rtl/delay_tap_ctrl_if.sv - request/finish bus between delay_tap_ctrl and smart_ram
interface delay_tap_ctrl_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [ADDR_WIDTH-1:0] mem_offset;
  logic                  mem_wr;
  logic                  mem_rd;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_write_finish;
  logic                  mem_read_finish;
  logic                  mem_available;

  // Controller side: issues requests, consumes finish strobes.
  modport master (
    output mem_data_in, mem_offset, mem_wr, mem_rd,
    input  mem_data_out, mem_write_finish, mem_read_finish, mem_available
  );

  // Buffer side: serves requests, returns finish strobes.
  modport slave (
    input  mem_data_in, mem_offset, mem_wr, mem_rd,
    output mem_data_out, mem_write_finish, mem_read_finish, mem_available
  );
endinterface

// File: rtl/delay_tap_ctrl.sv
// rtl/delay_tap_ctrl.sv - per-sample delay-line read/write sequencer with dry+wet mix; DELAY_FEEDBACK_EN enables recirculating feedback
module delay_tap_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  input  logic        [ADDR_WIDTH-1:0] delay,
  input  logic        [3:0]            wet_shift,
  input  logic        [3:0]            fb_shift,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         sample_out_valid,
  output logic                         busy,
  output logic                         overrun,
  delay_tap_ctrl_if.master             mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_OUT
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   dry_q, dry_d;
  logic signed [DATA_WIDTH-1:0]   tap_q, tap_d;
  logic        [ADDR_WIDTH-1:0]   rd_off_q, rd_off_d;
  logic        [DATA_WIDTH-1:0]   mem_data_in_q, mem_data_in_d;
  logic signed [DATA_WIDTH-1:0]   sample_out_q, sample_out_d;
  logic                           sample_out_valid_q, sample_out_valid_d;
  logic                           overrun_q, overrun_d;
  logic signed [DATA_WIDTH-1:0]   wr_word;
  logic signed [DATA_WIDTH-1:0]   wet;

  // Sum at one extra bit, then clamp to the signed sample range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      sat_add = s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_add = s[DATA_WIDTH-1:0];
    end
  endfunction

  assign wet = tap_q >>> wet_shift;

`ifdef DELAY_FEEDBACK_EN
  assign wr_word = sat_add(dry_q, tap_q >>> fb_shift);
`else
  logic unused_fb_shift;
  assign unused_fb_shift = ^fb_shift;
  assign wr_word         = dry_q;
`endif

  // Next-state, datapath capture and bus request decode.
  always_comb begin
    state_d            = state_q;
    dry_d              = dry_q;
    tap_d              = tap_q;
    rd_off_d           = rd_off_q;
    mem_data_in_d      = mem_data_in_q;
    sample_out_d       = sample_out_q;
    sample_out_valid_d = 1'b0;
    overrun_d          = sample_valid && (state_q != S_IDLE);
    mem.mem_rd         = 1'b0;
    mem.mem_wr         = 1'b0;
    mem.mem_offset     = '0;

    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          dry_d    = sample_in;
          // The buffer steps back offset+1 from its head, so a zero delay is treated as one.
          rd_off_d = (delay == '0) ? '0 : delay - ADDR_WIDTH'(1);
          state_d  = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        mem.mem_offset = rd_off_q;
        mem.mem_rd     = mem.mem_available;
        if (mem.mem_available) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        mem.mem_offset = rd_off_q;
        if (mem.mem_read_finish) begin
          tap_d   = mem.mem_data_out;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        mem_data_in_d = wr_word;
        mem.mem_wr    = mem.mem_available;
        if (mem.mem_available) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem.mem_write_finish) begin
          sample_out_d       = sat_add(dry_q, wet);
          sample_out_valid_d = 1'b1;
          state_d            = S_OUT;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      dry_q              <= '0;
      tap_q              <= '0;
      rd_off_q           <= '0;
      mem_data_in_q      <= '0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
      overrun_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      dry_q              <= dry_d;
      tap_q              <= tap_d;
      rd_off_q           <= rd_off_d;
      mem_data_in_q      <= mem_data_in_d;
      sample_out_q       <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
      overrun_q          <= overrun_d;
    end
  end

  assign mem.mem_data_in    = mem_data_in_d;
  assign sample_out         = sample_out_q;
  assign sample_out_valid   = sample_out_valid_q;
  assign overrun            = overrun_q;
  assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// tb/tb_delay_tap_ctrl.sv - self-checking bench for delay_tap_ctrl with a behavioural smart_ram
module tb_delay_tap_ctrl;
  localparam int AW   = 13;
  localparam int DW   = 16;
  localparam int MASK = (1 << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic signed [DW-1:0] sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic [AW-1:0]        delay = '0;
  logic [3:0]           wet_shift = '0;
  logic [3:0]           fb_shift = '0;
  logic signed [DW-1:0] sample_out;
  logic                 sample_out_valid;
  logic                 busy;
  logic                 overrun;

  int total = 0;
  int bad   = 0;

  delay_tap_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  delay_tap_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .delay            (delay),
    .wet_shift        (wet_shift),
    .fb_shift         (fb_shift),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .busy             (busy),
    .overrun          (overrun),
    .mem              (mem_bus)
  );

  // Behavioural smart_ram: read finishes 5 cycles after request, write 3 cycles after.
  bit signed [DW-1:0] ram_mem [0:MASK];
  logic [AW-1:0]      ram_head = '0;
  logic [AW-1:0]      rd_addr, pl_addr;
  logic signed [DW-1:0] rd_data = '0;
  int                 rd_cnt = 0;
  int                 wr_cnt = 0;
  logic               avail_en = 1'b1;
  logic               stray_rf = 1'b0;
  logic               stray_wf = 1'b0;
  logic               pl_en = 1'b0;
  logic signed [DW-1:0] pl_val = '0;

  assign rd_addr = ram_head - mem_bus.mem_offset - AW'(1);
  assign pl_addr = ram_head - AW'(1);
  assign mem_bus.mem_available    = avail_en && (rd_cnt == 0) && (wr_cnt == 0);
  assign mem_bus.mem_read_finish  = (rd_cnt == 1) || stray_rf;
  assign mem_bus.mem_write_finish = (wr_cnt == 1) || stray_wf;
  assign mem_bus.mem_data_out     = rd_data;

  always @(posedge clk) begin
    if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
    if (wr_cnt > 0) wr_cnt <= wr_cnt - 1;
    if (mem_bus.mem_rd) begin
      rd_data <= ram_mem[rd_addr];
      rd_cnt  <= 5;
    end
    if (mem_bus.mem_wr) begin
      ram_mem[ram_head] <= mem_bus.mem_data_in;
      ram_head          <= ram_head + AW'(1);
      wr_cnt            <= 3;
    end
    if (pl_en) ram_mem[pl_addr] <= pl_val;
  end

  // Reference model: history of written words indexed by absolute sample count.
  bit signed [DW-1:0] ref_mem [0:MASK];
  int ref_head = 0;

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_step(input int dry, input int dly, input int ws, input int fb,
                            output int exp_out, output int exp_wr, output int exp_off);
    int d, tap;
    d       = (dly == 0) ? 1 : dly;
    tap     = ref_mem[(ref_head - d) & MASK];
    exp_off = d - 1;
    exp_out = clamp16(dry + (tap >>> ws));
`ifdef DELAY_FEEDBACK_EN
    exp_wr  = clamp16(dry + (tap >>> fb));
`else
    exp_wr  = dry + 0 * fb;
`endif
    ref_mem[ref_head & MASK] = exp_wr[DW-1:0];
    ref_head++;
  endtask

  task automatic preload_last(input int v);
    @(posedge clk); #1;
    pl_val = v[DW-1:0];
    pl_en  = 1'b1;
    @(posedge clk); #1;
    pl_en  = 1'b0;
    ref_mem[(ref_head - 1) & MASK] = v[DW-1:0];
  endtask

  // Drives one sample (cycle 0 = acceptance) and records what the bus and outputs did.
  task automatic run_sample(input int din, input int dly, input int ws, input int fb,
                            input int s0, input int slen,
                            output int rd_cyc, output int rd_off, output int wr_cyc,
                            output int wr_data, output int wr_off, output int out_cyc,
                            output int out_val, output int idle_cyc, output int nrd,
                            output int nwr, output int nboth);
    rd_cyc = -1; rd_off = -1; wr_cyc = -1; wr_data = -99999; wr_off = -1;
    out_cyc = -1; out_val = -99999; idle_cyc = -1; nrd = 0; nwr = 0; nboth = 0;
    @(posedge clk); #1;
    sample_in    = din[DW-1:0];
    delay        = dly[AW-1:0];
    wet_shift    = ws[3:0];
    fb_shift     = fb[3:0];
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      avail_en = !(c >= s0 && c < s0 + slen);
      @(negedge clk);
      if (mem_bus.mem_rd && mem_bus.mem_wr) nboth++;
      if (mem_bus.mem_rd) begin
        nrd++; rd_cyc = c; rd_off = int'(mem_bus.mem_offset);
      end
      if (mem_bus.mem_wr) begin
        nwr++; wr_cyc = c; wr_data = int'($signed(mem_bus.mem_data_in));
        wr_off = int'(mem_bus.mem_offset);
      end
      if (sample_out_valid) begin
        out_cyc = c; out_val = int'(sample_out);
      end
      if (!busy) begin
        idle_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    avail_en = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (sample_out !== '0) begin bad++; $display("FAIL reset_sample_out: got %0d want 0", sample_out); end
    total++; if (sample_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", sample_out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    total++; if (mem_bus.mem_rd !== 1'b0 || mem_bus.mem_wr !== 1'b0) begin bad++; $display("FAIL reset_req: got rd=%0b wr=%0b want 0 0", mem_bus.mem_rd, mem_bus.mem_wr); end
    total++; if (mem_bus.mem_offset !== '0) begin bad++; $display("FAIL reset_offset: got %0d want 0", mem_bus.mem_offset); end
    total++; if (mem_bus.mem_data_in !== '0) begin bad++; $display("FAIL reset_data_in: got %0d want 0", mem_bus.mem_data_in); end
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_bus.mem_rd || mem_bus.mem_wr || sample_out_valid || busy) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", n); end
  endtask

  task automatic test_single();
    int rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb, eo, ew, eoff;
    model_step(32'h1000, 4, 1, 0, eo, ew, eoff);
    run_sample(32'h1000, 4, 1, 0, 0, 0, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
    total++; if (rc !== 1) begin bad++; $display("FAIL single_rd_cycle: got %0d want 1", rc); end
    total++; if (ro !== 3) begin bad++; $display("FAIL single_rd_offset: got %0d want 3", ro); end
    total++; if (wc !== 7) begin bad++; $display("FAIL single_wr_cycle: got %0d want 7", wc); end
    total++; if (wd !== 32'h1000 || wd !== ew) begin bad++; $display("FAIL single_wr_data: got %0d want %0d", wd, 32'h1000); end
    total++; if (wo !== 0) begin bad++; $display("FAIL single_wr_offset: got %0d want 0", wo); end
    total++; if (oc !== 11) begin bad++; $display("FAIL single_out_cycle: got %0d want 11", oc); end
    total++; if (ov !== 32'h1000 || ov !== eo) begin bad++; $display("FAIL single_out_value: got %0d want %0d", ov, 32'h1000); end
    total++; if (ic !== 12) begin bad++; $display("FAIL single_idle_cycle: got %0d want 12", ic); end
  endtask

  task automatic test_impulse();
    int rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb, eo, ew, eoff;
    int exp_c [6];
    int din;
    exp_c = '{16384, 0, 0, 8192, 0, 0};
    for (int i = 0; i < 3; i++) begin
      model_step(0, 3, 1, 0, eo, ew, eoff);
      run_sample(0, 3, 1, 0, 0, 0, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
    end
    for (int i = 0; i < 6; i++) begin
      din = (i == 0) ? 16384 : 0;
      model_step(din, 3, 1, 0, eo, ew, eoff);
      run_sample(din, 3, 1, 0, 0, 0, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
      total++; if (ov !== eo) begin bad++; $display("FAIL impulse_model[%0d]: got %0d want %0d", i, ov, eo); end
`ifndef DELAY_FEEDBACK_EN
      total++; if (ov !== exp_c[i]) begin bad++; $display("FAIL impulse_const[%0d]: got %0d want %0d", i, ov, exp_c[i]); end
`endif
    end
  endtask

  task automatic test_saturation();
    int rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb, eo, ew, eoff;
    preload_last(32'h7000);
    model_step(32'h7000, 1, 0, 0, eo, ew, eoff);
    run_sample(32'h7000, 1, 0, 0, 0, 0, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
    total++; if (ov !== 32767 || ov !== eo) begin bad++; $display("FAIL sat_pos: got %0d want 32767", ov); end
    total++; if (ro !== 0) begin bad++; $display("FAIL sat_rd_offset: got %0d want 0", ro); end
    preload_last(-28672);
    model_step(-28672, 0, 0, 0, eo, ew, eoff);
    run_sample(-28672, 0, 0, 0, 0, 0, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
    total++; if (ov !== -32768 || ov !== eo) begin bad++; $display("FAIL sat_neg: got %0d want -32768", ov); end
    total++; if (ro !== 0) begin bad++; $display("FAIL delay0_clamp_offset: got %0d want 0", ro); end
  endtask

  task automatic test_overrun();
    int eo, ew, eoff, n_ov, ov_cyc, n_out, out_v;
    n_ov = 0; ov_cyc = -1; n_out = 0; out_v = -99999;
    model_step(1234, 2, 2, 1, eo, ew, eoff);
    @(posedge clk); #1;
    sample_in = 16'sd1234; delay = 13'd2; wet_shift = 4'd2; fb_shift = 4'd1;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      sample_valid = (c == 5);
      sample_in    = (c == 5) ? 16'sd999 : 16'sd1234;
      @(negedge clk);
      if (overrun) begin n_ov++; ov_cyc = c; end
      if (sample_out_valid) begin n_out++; out_v = int'(sample_out); end
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    total++; if (n_ov !== 1) begin bad++; $display("FAIL overrun_count: got %0d want 1", n_ov); end
    total++; if (ov_cyc !== 6) begin bad++; $display("FAIL overrun_cycle: got %0d want 6", ov_cyc); end
    total++; if (n_out !== 1) begin bad++; $display("FAIL overrun_out_count: got %0d want 1", n_out); end
    total++; if (out_v !== eo) begin bad++; $display("FAIL overrun_out_value: got %0d want %0d", out_v, eo); end
  endtask

  task automatic test_stray_strobes();
    int n;
    n = 0;
    @(posedge clk); #1; stray_rf = 1'b1;
    @(posedge clk); #1; stray_rf = 1'b0; stray_wf = 1'b1;
    @(posedge clk); #1; stray_wf = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy || sample_out_valid || mem_bus.mem_rd || mem_bus.mem_wr) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL stray_ignored: got %0d active cycles want 0", n); end
  endtask

  task automatic test_stall();
    int rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb, eo, ew, eoff;
    model_step(-500, 5, 0, 2, eo, ew, eoff);
    run_sample(-500, 5, 0, 2, 1, 6, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
    total++; if (rc !== 7 || nr !== 1) begin bad++; $display("FAIL rd_stall: got cycle %0d count %0d want 7 1", rc, nr); end
    total++; if (ov !== eo) begin bad++; $display("FAIL rd_stall_value: got %0d want %0d", ov, eo); end
    model_step(777, 1, 3, 1, eo, ew, eoff);
    run_sample(777, 1, 3, 1, 7, 4, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
    total++; if (wc !== 11 || nw !== 1) begin bad++; $display("FAIL wr_stall: got cycle %0d count %0d want 11 1", wc, nw); end
    total++; if (oc !== 15 || ov !== eo) begin bad++; $display("FAIL wr_stall_out: got cycle %0d value %0d want 15 %0d", oc, ov, eo); end
  endtask

  task automatic test_reset_mid();
    int n_out, n_wr;
    n_out = 0; n_wr = 0;
    @(posedge clk); #1;
    sample_in = 16'sd3000; delay = 13'd1; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      rst = (c == 3);
      @(negedge clk);
      if (sample_out_valid) n_out++;
      if (mem_bus.mem_wr) n_wr++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (n_out !== 0 || n_wr !== 0) begin bad++; $display("FAIL reset_mid_abandon: got out=%0d wr=%0d want 0 0", n_out, n_wr); end
    total++; if (busy !== 1'b0 || sample_out !== '0) begin bad++; $display("FAIL reset_mid_state: got busy=%0b out=%0d want 0 0", busy, sample_out); end
  endtask

  task automatic test_feedback();
    int rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb, eo, ew, eoff, din;
    int written [5];
    for (int i = 0; i < 2; i++) begin
      model_step(0, 2, 1, 1, eo, ew, eoff);
      run_sample(0, 2, 1, 1, 0, 0, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
    end
    for (int i = 0; i < 5; i++) begin
      din = (i == 0) ? 16384 : 0;
      model_step(din, 2, 1, 1, eo, ew, eoff);
      run_sample(din, 2, 1, 1, 0, 0, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
      written[i] = wd;
      total++; if (wd !== ew || ov !== eo) begin bad++; $display("FAIL fb_model[%0d]: got wr=%0d out=%0d want %0d %0d", i, wd, ov, ew, eo); end
    end
`ifdef DELAY_FEEDBACK_EN
    total++; if (written[2] !== 8192) begin bad++; $display("FAIL fb_third: got %0d want 8192", written[2]); end
    total++; if (written[4] !== 4096) begin bad++; $display("FAIL fb_fifth: got %0d want 4096", written[4]); end
`else
    total++; if (written[2] !== 0) begin bad++; $display("FAIL nofb_third: got %0d want 0", written[2]); end
`endif
  endtask

  task automatic test_random();
    int rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb, eo, ew, eoff;
    int din, dly, ws, fb, s0, slen;
    logic [15:0] r;
    for (int i = 0; i < 24; i++) begin
      r    = 16'($urandom);
      din  = int'($signed(r));
      dly  = $urandom_range(0, 6);
      ws   = $urandom_range(0, 15);
      fb   = $urandom_range(0, 15);
      s0   = ($urandom_range(0, 2) == 0) ? 1 : 7;
      slen = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      model_step(din, dly, ws, fb, eo, ew, eoff);
      run_sample(din, dly, ws, fb, s0, slen, rc, ro, wc, wd, wo, oc, ov, ic, nr, nw, nb);
      total++; if (ov !== eo) begin bad++; $display("FAIL rand_out[%0d]: got %0d want %0d", i, ov, eo); end
      total++; if (wd !== ew) begin bad++; $display("FAIL rand_wr_data[%0d]: got %0d want %0d", i, wd, ew); end
      total++; if (ro !== eoff || wo !== 0) begin bad++; $display("FAIL rand_offsets[%0d]: got rd=%0d wr=%0d want %0d 0", i, ro, wo, eoff); end
      total++; if (nr !== 1 || nw !== 1 || nb !== 0) begin bad++; $display("FAIL rand_req_counts[%0d]: got rd=%0d wr=%0d both=%0d want 1 1 0", i, nr, nw, nb); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_impulse();
    test_saturation();
    test_overrun();
    test_stray_strobes();
    test_stall();
    test_reset_mid();
    test_feedback();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
